// File: rtl/l1_refill_arbiter_pkg.sv
// Shared types and helpers for the L1 refill arbiter: FSM states,
// burst-owner encoding, default line size and the round-robin pick.
package l1_refill_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_DONE} arb_state_e;

  typedef enum logic {OWN_I, OWN_D} arb_owner_e;

  localparam int unsigned LINE_WORDS_DEF = 4;

  // Round-robin pick: a lone requester wins; on a tie the side that did
  // not own the previous burst wins.
  function automatic arb_owner_e pick_owner(input logic ic_req,
                                            input logic dc_req,
                                            input arb_owner_e last_owner);
    if (ic_req && dc_req) begin
      return (last_owner == OWN_I) ? OWN_D : OWN_I;
    end
    return dc_req ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/l1_refill_arbiter.sv
// L1 refill arbiter: shares the single external memory port between
// I-cache line refills and D-cache refills/writebacks. A granted side owns
// the port for a full fixed-length line burst; read beats are steered back
// to the owner combinationally, and busy freezes the pipeline meanwhile.
module l1_refill_arbiter
  import l1_refill_arbiter_pkg::*;
#(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LINE_WORDS = LINE_WORDS_DEF,
  localparam int BEAT_W     = $clog2(LINE_WORDS),
  localparam int OFF        = BEAT_W + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_rvalid,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic                  ic_done,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [DATA_WIDTH-1:0] dc_wdata,
  output logic                  dc_rvalid,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic                  dc_done,
  output logic [BEAT_W-1:0]     beat,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  arb_state_e                state_q, state_d;
  arb_owner_e                owner_q, owner_d;
  arb_owner_e                last_owner_q, last_owner_d;
  logic [ADDR_WIDTH-OFF-1:0] line_q, line_d;
  logic                      we_q, we_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic                      last_beat;

  // The word-offset bits of the request addresses are intentionally ignored.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{ic_addr[OFF-1:0], dc_addr[OFF-1:0]};

  assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));

  // Read data goes to both caches; only the owner's rvalid qualifies it.
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;
  assign beat     = beat_q;
  assign busy     = (state_q != ARB_IDLE) | ic_req | dc_req;

  // Next-state logic, grant decision and per-beat memory/steering outputs.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no
    // path through the case statement leaves one unassigned (no latches).
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    line_d       = line_q;
    we_d         = we_q;
    beat_d       = beat_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_rvalid    = 1'b0;
    dc_rvalid    = 1'b0;
    ic_done      = 1'b0;
    dc_done      = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (ic_req || dc_req) begin
          owner_d = pick_owner(ic_req, dc_req, last_owner_q);
          line_d  = (owner_d == OWN_D) ? dc_addr[ADDR_WIDTH-1:OFF]
                                       : ic_addr[ADDR_WIDTH-1:OFF];
          we_d    = (owner_d == OWN_D) && dc_we;
          beat_d  = '0;
          state_d = ARB_BURST;
        end
      end

      ARB_BURST: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {line_q, beat_q, 2'b00};
        if (owner_q == OWN_D && we_q) begin
          mem_wdata = dc_wdata;
        end
        if (mem_ack) begin
          if (!we_q) begin
            ic_rvalid = (owner_q == OWN_I);
            dc_rvalid = (owner_q == OWN_D);
          end
          if (last_beat) begin
            ic_done      = (owner_q == OWN_I);
            dc_done      = (owner_q == OWN_D);
            last_owner_d = owner_q;
            state_d      = ARB_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      ARB_DONE: begin
        // One dead cycle so the finished owner can drop its stale request.
        beat_d  = '0;
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  // State register; reset discards any burst in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      line_q       <= '0;
      we_q         <= 1'b0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      line_q       <= line_d;
      we_q         <= we_d;
      beat_q       <= beat_d;
    end
  end

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Self-checking bench for l1_refill_arbiter: directed scenarios for reset,
// single refill, tie alternation, waited writeback, mid-burst reset and the
// DONE dead cycle, then a randomized run against a transaction-level model.
module tb_l1_refill_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_rvalid;
  logic [DW-1:0] ic_rdata;
  logic          ic_done;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_rvalid;
  logic [DW-1:0] dc_rdata;
  logic          dc_done;
  logic [1:0]    beat;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks = 0;
  int errors = 0;

  l1_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid),
    .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .beat(beat), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0; dc_addr = '0;
    dc_wdata = '0; mem_ack = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    mem_ack = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if ({ic_rvalid, dc_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {ic_rvalid, dc_rvalid}); end
    checks++; if ({ic_done, dc_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", {ic_done, dc_done}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (beat !== 2'd0) begin errors++; $display("FAIL reset_beat: got %0d want 0", beat); end
    mem_ack = 0;
  endtask

  task automatic test_single_ic();
    do_reset();
    ic_req = 1; ic_addr = 32'h0000_1038; mem_ack = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL single_grant_req: got %b want 0", mem_req); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_grant_busy: got %b want 1", busy); end
    tick();
    for (int b = 0; b < LW; b++) begin
      mem_rdata = $urandom;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL single_req_we b%0d: got %b%b want 10", b, mem_req, mem_we); end
      checks++; if (mem_addr !== 32'h1030 + 32'(4 * b)) begin errors++; $display("FAIL single_addr b%0d: got %h want %h", b, mem_addr, 32'h1030 + 32'(4 * b)); end
      checks++; if (beat !== 2'(b)) begin errors++; $display("FAIL single_beat: got %0d want %0d", beat, b); end
      checks++; if (ic_rvalid !== 1'b1 || ic_rdata !== mem_rdata) begin errors++; $display("FAIL single_rdata b%0d: got v=%b %h want v=1 %h", b, ic_rvalid, ic_rdata, mem_rdata); end
      checks++; if (ic_done !== (b == LW - 1)) begin errors++; $display("FAIL single_done b%0d: got %b want %b", b, ic_done, b == LW - 1); end
      checks++; if (dc_rvalid !== 1'b0 || dc_done !== 1'b0) begin errors++; $display("FAIL single_dside b%0d: got %b%b want 00", b, dc_rvalid, dc_done); end
      tick();
    end
    ic_req = 0;
    #1;
    checks++; if (mem_req !== 1'b0 || ic_rvalid !== 1'b0) begin errors++; $display("FAIL single_donecyc: got req=%b rv=%b want 0 0", mem_req, ic_rvalid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_donecyc_busy: got %b want 1", busy); end
    tick();
    #1;
    checks++; if (busy !== 1'b0 || beat !== 2'd0) begin errors++; $display("FAIL single_idle: got busy=%b beat=%0d want 0 0", busy, beat); end
    mem_ack = 0;
  endtask

  task automatic test_tie();
    bit exp_d;
    int idle;
    do_reset();
    ic_req = 1; ic_addr = 32'h0000_1000;
    dc_req = 1; dc_we = 0; dc_addr = 32'h0000_2004;
    mem_ack = 1;
    exp_d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle = 0;
      #1;
      while (mem_req !== 1'b1 && idle < 10) begin
        tick();
        #1;
        idle++;
      end
      checks++; if (idle != ((k == 0) ? 1 : 2)) begin errors++; $display("FAIL tie_gap k%0d: got %0d want %0d", k, idle, (k == 0) ? 1 : 2); end
      for (int b = 0; b < LW; b++) begin
        mem_rdata = $urandom;
        #1;
        checks++; if (mem_addr !== (exp_d ? 32'h2000 : 32'h1000) + 32'(4 * b)) begin errors++; $display("FAIL tie_addr k%0d b%0d: got %h want %h", k, b, mem_addr, (exp_d ? 32'h2000 : 32'h1000) + 32'(4 * b)); end
        checks++; if ({dc_rvalid, ic_rvalid} !== {exp_d, ~exp_d}) begin errors++; $display("FAIL tie_owner k%0d b%0d: got d=%b i=%b want d=%b", k, b, dc_rvalid, ic_rvalid, exp_d); end
        checks++; if ({dc_done, ic_done} !== ((b == LW - 1) ? {exp_d, ~exp_d} : 2'b00)) begin errors++; $display("FAIL tie_done k%0d b%0d: got %b%b", k, b, dc_done, ic_done); end
        tick();
      end
      exp_d = ~exp_d;
    end
    drive_idle();
  endtask

  task automatic test_write_waits();
    int cyc;
    int beats;
    int dones;
    do_reset();
    dc_req = 1; dc_we = 1; dc_addr = 32'h0000_2000;
    tick();
    cyc = 0; beats = 0; dones = 0;
    while (beats < LW && cyc < 40) begin
      mem_ack = (cyc % 3 == 2);
      dc_wdata = 32'hA5A5_0000 + 32'(beats);
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_req_we c%0d: got %b%b want 11", cyc, mem_req, mem_we); end
      checks++; if (mem_addr !== 32'h2000 + 32'(4 * beats)) begin errors++; $display("FAIL wr_addr c%0d: got %h want %h", cyc, mem_addr, 32'h2000 + 32'(4 * beats)); end
      checks++; if (mem_wdata !== dc_wdata) begin errors++; $display("FAIL wr_wdata c%0d: got %h want %h", cyc, mem_wdata, dc_wdata); end
      checks++; if (dc_rvalid !== 1'b0) begin errors++; $display("FAIL wr_rvalid c%0d: got %b want 0", cyc, dc_rvalid); end
      checks++; if (dc_done !== (mem_ack && beats == LW - 1)) begin errors++; $display("FAIL wr_done c%0d: got %b want %b", cyc, dc_done, mem_ack && beats == LW - 1); end
      if (dc_done === 1'b1) dones++;
      if (mem_ack) beats++;
      tick();
      cyc++;
    end
    checks++; if (beats != LW) begin errors++; $display("FAIL wr_timeout: got %0d beats want %0d", beats, LW); end
    dc_req = 0; mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (dc_done === 1'b1) dones++;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wr_after c%0d: got mem_req %b want 0", i, mem_req); end
      tick();
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL wr_done_count: got %0d want 1", dones); end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ic_req = 1; ic_addr = 32'h0000_3000; mem_ack = 1;
    tick();
    tick();
    tick();
    mem_ack = 0;
    #1;
    checks++; if (beat !== 2'd2 || mem_addr !== 32'h3008) begin errors++; $display("FAIL rstmid_pre: got beat=%0d addr=%h want 2 3008", beat, mem_addr); end
    rst = 1;
    tick();
    rst = 0; ic_req = 0; mem_ack = 1;
    #1;
    checks++; if (mem_req !== 1'b0 || beat !== 2'd0) begin errors++; $display("FAIL rstmid_post: got req=%b beat=%0d want 0 0", mem_req, beat); end
    checks++; if (ic_done !== 1'b0 || ic_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_nodone: got done=%b rv=%b want 0 0", ic_done, ic_rvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    tick();
    #1;
    checks++; if (mem_req !== 1'b0 || ic_done !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got req=%b done=%b want 0 0", mem_req, ic_done); end
    drive_idle();
  endtask

  task automatic test_done_hold();
    do_reset();
    ic_req = 1; ic_addr = 32'h0000_4000; mem_ack = 1;
    for (int i = 0; i < 1 + LW; i++) tick();
    #1;
    checks++; if (mem_req !== 1'b0 || ic_rvalid !== 1'b0 || ic_done !== 1'b0) begin errors++; $display("FAIL hold_donecyc: got req=%b rv=%b done=%b want 000", mem_req, ic_rvalid, ic_done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b want 1", busy); end
    tick();
    #1;
    checks++; if (mem_req !== 1'b0 || ic_rvalid !== 1'b0) begin errors++; $display("FAIL hold_idlecyc: got req=%b rv=%b want 00", mem_req, ic_rvalid); end
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000 || ic_rvalid !== 1'b1) begin errors++; $display("FAIL hold_regrant: got req=%b addr=%h rv=%b want 1 4000 1", mem_req, mem_addr, ic_rvalid); end
    drive_idle();
  endtask

  task automatic test_random();
    bit       m_act, m_gap, m_own_d, m_last_d, m_we;
    logic [AW-1:0] m_line;
    int       m_beat;
    bit       e_last;
    bit       ic_saw, dc_saw, allow_new;
    int       ic_iss, ic_dn, dc_iss, dc_dn, flush;
    logic [AW-1:0] e_addr;
    do_reset();
    m_act = 0; m_gap = 0; m_own_d = 0; m_last_d = 0; m_we = 0; m_line = '0; m_beat = 0;
    ic_saw = 0; dc_saw = 0; allow_new = 1;
    ic_iss = 0; ic_dn = 0; dc_iss = 0; dc_dn = 0; flush = 0;
    for (int cyc = 0; cyc < 10300; cyc++) begin
      if (cyc == 10000) allow_new = 0;
      if (!allow_new && !ic_req && !dc_req && !m_act && !m_gap) break;
      // Cache behaviour: hold request until done, then drop or issue a new miss.
      if (ic_saw) begin
        ic_saw = 0;
        if (!allow_new || $urandom_range(0, 1) == 0) ic_req = 0;
        else begin ic_addr = $urandom; ic_iss++; end
      end else if (!ic_req && allow_new && $urandom_range(0, 7) == 0) begin
        ic_req = 1; ic_addr = $urandom; ic_iss++;
      end
      if (dc_saw) begin
        dc_saw = 0;
        if (!allow_new || $urandom_range(0, 1) == 0) dc_req = 0;
        else begin dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1)); dc_iss++; end
      end else if (!dc_req && allow_new && $urandom_range(0, 7) == 0) begin
        dc_req = 1; dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1)); dc_iss++;
      end
      mem_ack = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_rdata = $urandom;
      dc_wdata = $urandom;
      #1;
      e_last = m_act && mem_ack && (m_beat == LW - 1);
      e_addr = m_act ? (m_line + 32'(4 * m_beat)) : 32'h0;
      checks++; if (mem_req !== m_act || mem_we !== (m_act && m_we)) begin errors++; $display("FAIL rnd_req_we c%0d: got %b%b want %b%b", cyc, mem_req, mem_we, m_act, m_act && m_we); end
      checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, mem_addr, e_addr); end
      checks++; if (beat !== 2'(m_gap ? LW - 1 : (m_act ? m_beat : 0))) begin errors++; $display("FAIL rnd_beat c%0d: got %0d", cyc, beat); end
      checks++; if (ic_rvalid !== (m_act && mem_ack && !m_own_d && !m_we) || dc_rvalid !== (m_act && mem_ack && m_own_d && !m_we)) begin errors++; $display("FAIL rnd_rvalid c%0d: got i=%b d=%b", cyc, ic_rvalid, dc_rvalid); end
      checks++; if (ic_done !== (e_last && !m_own_d) || dc_done !== (e_last && m_own_d)) begin errors++; $display("FAIL rnd_done c%0d: got i=%b d=%b", cyc, ic_done, dc_done); end
      checks++; if (busy !== (m_act || m_gap || ic_req || dc_req)) begin errors++; $display("FAIL rnd_busy c%0d: got %b", cyc, busy); end
      if (m_act && !m_we && mem_ack) begin
        checks++; if ((m_own_d ? dc_rdata : ic_rdata) !== mem_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, m_own_d ? dc_rdata : ic_rdata, mem_rdata); end
      end
      if (m_act && m_own_d && m_we) begin
        checks++; if (mem_wdata !== dc_wdata) begin errors++; $display("FAIL rnd_wdata c%0d: got %h want %h", cyc, mem_wdata, dc_wdata); end
      end
      if (ic_done === 1'b1) begin ic_dn++; ic_saw = 1; end
      if (dc_done === 1'b1) begin dc_dn++; dc_saw = 1; end
      // Transaction model: a line burst, one dead cycle, then a new grant.
      if (m_act) begin
        if (mem_ack) begin
          if (m_beat == LW - 1) begin m_act = 0; m_gap = 1; m_last_d = m_own_d; end
          else m_beat++;
        end
      end else if (m_gap) begin
        m_gap = 0;
      end else if (ic_req || dc_req) begin
        m_own_d = (ic_req && dc_req) ? !m_last_d : dc_req;
        m_line  = (m_own_d ? dc_addr : ic_addr) & ~32'hF;
        m_we    = m_own_d && dc_we;
        m_beat  = 0;
        m_act   = 1;
      end
      if (!allow_new) flush++;
      tick();
    end
    checks++; if (ic_req || dc_req || m_act) begin errors++; $display("FAIL rnd_flush_timeout: reqs=%b%b active=%b after %0d cycles", ic_req, dc_req, m_act, flush); end
    checks++; if (ic_iss != ic_dn) begin errors++; $display("FAIL rnd_ic_count: got %0d dones want %0d", ic_dn, ic_iss); end
    checks++; if (dc_iss != dc_dn) begin errors++; $display("FAIL rnd_dc_count: got %0d dones want %0d", dc_dn, dc_iss); end
    drive_idle();
  endtask

  initial begin
    rst = 1;
    drive_idle();
    test_reset();
    test_single_ic();
    test_tie();
    test_write_waits();
    test_reset_mid();
    test_done_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
